cla_8bit: RTL and testbench

- 8-bit carry-lookahead adder with a registered result: out/cout = in1 + in2 + cin, captured on the rising clock edge.
- Built from two 4-bit lookahead groups joined by a second-level lookahead carry. There is no ripple chain.
- Exports block propagate/generate so blocks can be cascaded into wider adders, e.g. a 16-bit adder inside the FPU mantissa datapath.

---
 rtl/cla_8bit_if.sv | 14 +
 rtl/cla_8bit.sv | 59 +++++
 tb/tb_cla_8bit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cla_8bit_if.sv
// Operand/result bundle for the 8-bit lookahead adder.
// master drives the addends, slave returns the registered sum and block P/G.
interface cla_8bit_if;
  logic [7:0] in1;
  logic [7:0] in2;
  logic       cin;
  logic [7:0] out;
  logic       cout;
  logic       blk_p;
  logic       blk_g;

  modport master (output in1, in2, cin, input out, cout, blk_p, blk_g);
  modport slave  (input in1, in2, cin, output out, cout, blk_p, blk_g);
endinterface

// File: rtl/cla_8bit.sv
// 8-bit two-level carry-lookahead adder with a registered sum and block P/G; latency 1 cycle.
// No backpressure: every rising edge out of reset captures a new result.
module cla_8bit (
  input  logic       clk,
  input  logic       rst_n,
  cla_8bit_if.slave  bus
);
  logic [7:0] g;
  logic [7:0] p;
  logic [7:0] c;
  logic [7:0] out_d;
  logic       pg0, gg0, pg1, gg1;
  logic       cout_d, blk_p_d, blk_g_d;
  logic [7:0] out_q;
  logic       cout_q, blk_p_q, blk_g_q;

  assign g = bus.in1 & bus.in2;
  assign p = bus.in1 ^ bus.in2;

  // Low group: carries flattened to sum-of-products from cin.
  assign c[0] = bus.cin;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign pg0  = p[3] & p[2] & p[1] & p[0];
  assign gg0  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

  assign c[4] = gg0 | (pg0 & bus.cin);
  assign c[5] = g[4] | (p[4] & c[4]);
  assign c[6] = g[5] | (p[5] & g[4]) | (p[5] & p[4] & c[4]);
  assign c[7] = g[6] | (p[6] & g[5]) | (p[6] & p[5] & g[4]) | (p[6] & p[5] & p[4] & c[4]);
  assign pg1  = p[7] & p[6] & p[5] & p[4];
  assign gg1  = g[7] | (p[7] & g[6]) | (p[7] & p[6] & g[5]) | (p[7] & p[6] & p[5] & g[4]);

  // Second level: block P/G exclude cin so wider adders can cascade on them.
  assign cout_d  = gg1 | (pg1 & gg0) | (pg1 & pg0 & bus.cin);
  assign blk_p_d = pg1 & pg0;
  assign blk_g_d = gg1 | (pg1 & gg0);
  assign out_d   = p ^ c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= 8'h00;
      cout_q  <= 1'b0;
      blk_p_q <= 1'b0;
      blk_g_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      cout_q  <= cout_d;
      blk_p_q <= blk_p_d;
      blk_g_q <= blk_g_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.cout  = cout_q;
  assign bus.blk_p = blk_p_q;
  assign bus.blk_g = blk_g_q;
endmodule

// File: tb/tb_cla_8bit.sv
// Directed and swept checks of cla_8bit against hand-computed and behavioural sums.
module tb_cla_8bit;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  cla_8bit_if bus ();

  cla_8bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic ci);
    bus.in1 = a;
    bus.in2 = b;
    bus.cin = ci;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(8'hF0, 8'hF0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      total++;
      if ({bus.out, bus.cout, bus.blk_p, bus.blk_g} !== 11'h000) begin
        bad++;
        $display("FAIL reset_hold: got out=%h cout=%b p=%b g=%b want 00 0 0 0",
                 bus.out, bus.cout, bus.blk_p, bus.blk_g);
      end
    end
    #2 rst_n = 1'b1;
    #1;
    total++;
    if (bus.out !== 8'h00 || bus.cout !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_noedge: got out=%h cout=%b want 00 0", bus.out, bus.cout);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.out !== 8'hE1 || bus.cout !== 1'b1 || bus.blk_p !== 1'b0 || bus.blk_g !== 1'b1) begin
      bad++;
      $display("FAIL reset_first: got out=%h cout=%b p=%b g=%b want E1 1 0 1",
               bus.out, bus.cout, bus.blk_p, bus.blk_g);
    end
  endtask

  task automatic test_sweep;
    logic [7:0] v;
    logic [8:0] exp;
    for (int i = 0; i < 32; i++) begin
      v = 8'(8'hF0 + i);
      drive(v, v, 1'b1);
      exp = {1'b0, v} + {1'b0, v} + 9'd1;
      @(posedge clk);
      #1;
      total++;
      if ({bus.cout, bus.out} !== exp) begin
        bad++;
        $display("FAIL sweep v=%h: got %b_%h want %b_%h", v, bus.cout, bus.out, exp[8], exp[7:0]);
      end
      if (v == 8'hF1 || v == 8'hFF || v == 8'h00) begin
        total++;
        if ((v == 8'hF1 && {bus.cout, bus.out} !== 9'h1E3) ||
            (v == 8'hFF && {bus.cout, bus.out} !== 9'h1FF) ||
            (v == 8'h00 && {bus.cout, bus.out} !== 9'h001)) begin
          bad++;
          $display("FAIL sweep_point v=%h: got cout=%b out=%h", v, bus.cout, bus.out);
        end
      end
    end
  endtask

  task automatic test_propagate_chain;
    drive(8'hFF, 8'h00, 1'b1);
    @(posedge clk);
    #1;
    total++;
    if (bus.out !== 8'h00 || bus.cout !== 1'b1 || bus.blk_p !== 1'b1 || bus.blk_g !== 1'b0) begin
      bad++;
      $display("FAIL prop_cin1: got out=%h cout=%b p=%b g=%b want 00 1 1 0",
               bus.out, bus.cout, bus.blk_p, bus.blk_g);
    end
    drive(8'hFF, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    total++;
    if (bus.out !== 8'hFF || bus.cout !== 1'b0 || bus.blk_p !== 1'b1 || bus.blk_g !== 1'b0) begin
      bad++;
      $display("FAIL prop_cin0: got out=%h cout=%b p=%b g=%b want FF 0 1 0",
               bus.out, bus.cout, bus.blk_p, bus.blk_g);
    end
  endtask

  task automatic test_group_boundary;
    drive(8'h0F, 8'h01, 1'b0);
    @(posedge clk);
    #1;
    total++;
    if (bus.out !== 8'h10 || bus.cout !== 1'b0 || bus.blk_p !== 1'b0 || bus.blk_g !== 1'b0) begin
      bad++;
      $display("FAIL grp_0f01: got out=%h cout=%b p=%b g=%b want 10 0 0 0",
               bus.out, bus.cout, bus.blk_p, bus.blk_g);
    end
    drive(8'h80, 8'h80, 1'b0);
    @(posedge clk);
    #1;
    total++;
    if (bus.out !== 8'h00 || bus.cout !== 1'b1 || bus.blk_p !== 1'b0 || bus.blk_g !== 1'b1) begin
      bad++;
      $display("FAIL grp_8080: got out=%h cout=%b p=%b g=%b want 00 1 0 1",
               bus.out, bus.cout, bus.blk_p, bus.blk_g);
    end
  endtask

  // Every in1 against a set of corner/pattern in2 values, both cin, one vector per cycle.
  task automatic test_back_to_back;
    logic [7:0] blist [16];
    logic [7:0] a;
    logic [8:0] exp;
    logic [8:0] nocin;
    logic       ep, eg;
    blist = '{8'h00, 8'h01, 8'h0F, 8'h10, 8'h7F, 8'h80, 8'hF0, 8'hFF,
              8'h55, 8'hAA, 8'h33, 8'hCC, 8'h0E, 8'hF1, 8'h3C, 8'hC3};
    for (int ai = 0; ai < 256; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          a = 8'(ai);
          drive(a, blist[bi], 1'(ci));
          exp   = {1'b0, a} + {1'b0, blist[bi]} + 9'(ci);
          nocin = {1'b0, a} + {1'b0, blist[bi]};
          ep    = &(a ^ blist[bi]);
          eg    = nocin[8];
          @(posedge clk);
          #1;
          total++;
          if ({bus.cout, bus.out} !== exp || bus.blk_p !== ep || bus.blk_g !== eg ||
              bus.cout !== (bus.blk_g | (bus.blk_p & 1'(ci)))) begin
            bad++;
            $display("FAIL b2b a=%h b=%h c=%0d: got %b_%h p=%b g=%b want %b_%h p=%b g=%b",
                     a, blist[bi], ci, bus.cout, bus.out, bus.blk_p, bus.blk_g,
                     exp[8], exp[7:0], ep, eg);
          end
        end
      end
    end
  endtask

  task automatic test_async_reset;
    drive(8'hF0, 8'hF0, 1'b1);
    @(posedge clk);
    #1;
    total++;
    if (bus.out !== 8'hE1 || bus.cout !== 1'b1) begin
      bad++;
      $display("FAIL async_pre: got out=%h cout=%b want E1 1", bus.out, bus.cout);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (bus.out !== 8'h00 || bus.cout !== 1'b0 || bus.blk_g !== 1'b0) begin
      bad++;
      $display("FAIL async_clear: got out=%h cout=%b g=%b want 00 0 0", bus.out, bus.cout, bus.blk_g);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.out !== 8'h00 || bus.cout !== 1'b0) begin
      bad++;
      $display("FAIL async_hold: got out=%h cout=%b want 00 0", bus.out, bus.cout);
    end
    #2 rst_n = 1'b1;
    drive(8'h12, 8'h34, 1'b1);
    @(posedge clk);
    #1;
    total++;
    if (bus.out !== 8'h47 || bus.cout !== 1'b0 || bus.blk_p !== 1'b0 || bus.blk_g !== 1'b0) begin
      bad++;
      $display("FAIL async_after: got out=%h cout=%b p=%b g=%b want 47 0 0 0",
               bus.out, bus.cout, bus.blk_p, bus.blk_g);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_sweep();
    test_propagate_chain();
    test_group_boundary();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
